// File: rtl/device_info_read_master.sv
// AXI4 read master: fetches 1..C_MAX_BEATS device-info words and forwards them on a valid/ready stream.
// Optional DEVICE_INFO_RRESP_CHECK_EN: non-OKAY rresp on any beat also raises ctrl_error.
module device_info_read_master #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 64,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 512,
  parameter int unsigned C_MAX_BEATS        = 16
) (
  input  logic                          aclk,
  input  logic                          areset_n,
  input  logic                          ctrl_start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset,
  input  logic [8:0]                    ctrl_beats,
  output logic                          ctrl_busy,
  output logic                          ctrl_done,
  output logic                          ctrl_error,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic                          m_axi_rlast,
  input  logic [1:0]                    m_axi_rresp,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [C_M_AXI_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                          m_axis_tlast
);

  localparam int unsigned DW_BYTES = C_M_AXI_DATA_WIDTH / 8;
  localparam int unsigned ALIGN    = C_MAX_BEATS * DW_BYTES;
  localparam int unsigned CNT_W    = $clog2(C_MAX_BEATS) + 1;
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ALIGN_MASK = ~(C_M_AXI_ADDR_WIDTH'(ALIGN - 1));

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_DRAIN, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   beats_r;
  logic [CNT_W-1:0]   beat_cnt;
  logic [CNT_W-1:0]   beats_clamped_c;
  logic               start_acc_c;
  logic               r_hs_c;
  logic               last_beat_c;
  logic               beat_err_c;
  logic               rready_c;

  assign beats_clamped_c = (ctrl_beats > 9'(C_MAX_BEATS)) ? CNT_W'(C_MAX_BEATS) : CNT_W'(ctrl_beats);
  assign start_acc_c     = (state == S_IDLE) && ctrl_start;
  assign r_hs_c          = m_axi_rvalid && rready_c;
  assign last_beat_c     = (beat_cnt == CNT_W'(beats_r - CNT_W'(1)));
  assign m_axi_rready    = rready_c;

`ifdef DEVICE_INFO_RRESP_CHECK_EN
  assign beat_err_c = (m_axi_rlast != last_beat_c) || (m_axi_rresp != 2'b00);
`else
  logic unused_rresp;
  assign unused_rresp = ^m_axi_rresp;
  assign beat_err_c   = (m_axi_rlast != last_beat_c);
`endif

  // Next-state and read-accept logic
  always_comb begin
    state_nxt = state;
    rready_c  = 1'b0;
    case (state)
      S_IDLE: begin
        if (ctrl_start) state_nxt = (beats_clamped_c == '0) ? S_DRAIN : S_ADDR;
      end
      S_ADDR: begin
        if (m_axi_arready) state_nxt = S_DATA;
      end
      S_DATA: begin
        rready_c = !m_axis_tvalid || m_axis_tready;
        if (m_axi_rvalid && rready_c && last_beat_c) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        // Only the tlast word can be held here; a zero-beat request has nothing to drain
        if (!m_axis_tvalid || (m_axis_tready && m_axis_tlast)) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, control outputs and request latches
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state         <= S_IDLE;
      beats_r       <= '0;
      beat_cnt      <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      ctrl_busy     <= 1'b0;
      ctrl_done     <= 1'b0;
      ctrl_error    <= 1'b0;
    end else begin
      state         <= state_nxt;
      m_axi_arvalid <= (state_nxt == S_ADDR);
      ctrl_busy     <= (state_nxt == S_ADDR) || (state_nxt == S_DATA) || (state_nxt == S_DRAIN);
      ctrl_done     <= (state_nxt == S_DONE);
      if (start_acc_c) begin
        beats_r      <= beats_clamped_c;
        beat_cnt     <= '0;
        m_axi_araddr <= ctrl_addr_offset & ALIGN_MASK;
        m_axi_arlen  <= 8'(beats_clamped_c - CNT_W'(1));
        ctrl_error   <= 1'b0;
      end else if (r_hs_c) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
        if (beat_err_c) ctrl_error <= 1'b1;
      end
    end
  end

  // One-deep output register; a new beat may load while the old word leaves
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (r_hs_c) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= m_axi_rdata;
      m_axis_tlast  <= last_beat_c;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule
